// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I integer subset CPU with one shared Avalon-style bus.
// Fetch and data accesses take turns on the port; $v0 is exported.
module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_ir, w_ir;
    logic [31:0] r_tgt, w_tgt;
    logic        r_pend, w_pend;
    logic        r_read, w_read;
    logic        r_write, w_write;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [31:0] r_gpr [32];

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh;
    logic [31:0] w_rsv, w_rtv, w_simm, w_zimm;
    logic [31:0] w_pc4, w_mem_sum;
    logic [31:0] w_alu, w_br_tgt;
    logic [4:0]  w_dst;
    logic        w_alu_we, w_br, w_lw, w_sw;
    logic        w_wb_en, w_launch;
    logic [4:0]  w_wb_dst;
    logic [31:0] w_wb_data, w_fetch_pc;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_sh      = r_ir[10:6];
    assign w_fn      = r_ir[5:0];
    assign w_simm    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zimm    = {16'h0000, r_ir[15:0]};
    assign w_rsv     = r_gpr[w_rs];
    assign w_rtv     = r_gpr[w_rt];
    assign w_pc4     = r_pc + 32'd4;
    assign w_mem_sum = w_rsv + w_simm;

    assign active      = (r_state != S_HALT);
    assign register_v0 = r_gpr[2];
    assign address     = r_addr;
    assign read        = r_read;
    assign write       = r_write;
    assign writedata   = r_wdata;
    assign byteenable  = 4'b1111;

    always_comb begin
        w_alu    = '0;
        w_dst    = w_rt;
        w_alu_we = 1'b0;
        w_br     = 1'b0;
        w_br_tgt = w_pc4 + (w_simm << 2);
        w_lw     = 1'b0;
        w_sw     = 1'b0;
        case (w_op)
            6'h00: begin
                w_dst    = w_rd;
                w_alu_we = 1'b1;
                case (w_fn)
                    6'h00: w_alu = w_rtv << w_sh;
                    6'h02: w_alu = w_rtv >> w_sh;
                    6'h03: w_alu = $signed(w_rtv) >>> w_sh;
                    6'h04: w_alu = w_rtv << w_rsv[4:0];
                    6'h06: w_alu = w_rtv >> w_rsv[4:0];
                    6'h07: w_alu = $signed(w_rtv) >>> w_rsv[4:0];
                    6'h08: begin
                        w_alu_we = 1'b0;
                        w_br     = 1'b1;
                        w_br_tgt = w_rsv;
                    end
                    6'h21: w_alu = w_rsv + w_rtv;
                    6'h23: w_alu = w_rsv - w_rtv;
                    6'h24: w_alu = w_rsv & w_rtv;
                    6'h25: w_alu = w_rsv | w_rtv;
                    6'h26: w_alu = w_rsv ^ w_rtv;
                    6'h2A: w_alu = {31'd0, $signed(w_rsv) < $signed(w_rtv)};
                    6'h2B: w_alu = {31'd0, w_rsv < w_rtv};
                    default: w_alu_we = 1'b0;
                endcase
            end
            6'h02: begin
                w_br     = 1'b1;
                w_br_tgt = {w_pc4[31:28], r_ir[25:0], 2'b00};
            end
            6'h04: w_br = (w_rsv == w_rtv);
            6'h05: w_br = (w_rsv != w_rtv);
            6'h09: begin w_alu = w_rsv + w_simm; w_alu_we = 1'b1; end
            6'h0A: begin
                w_alu    = {31'd0, $signed(w_rsv) < $signed(w_simm)};
                w_alu_we = 1'b1;
            end
            6'h0B: begin w_alu = {31'd0, w_rsv < w_simm}; w_alu_we = 1'b1; end
            6'h0C: begin w_alu = w_rsv & w_zimm; w_alu_we = 1'b1; end
            6'h0D: begin w_alu = w_rsv | w_zimm; w_alu_we = 1'b1; end
            6'h0E: begin w_alu = w_rsv ^ w_zimm; w_alu_we = 1'b1; end
            6'h0F: begin w_alu = {r_ir[15:0], 16'h0000}; w_alu_we = 1'b1; end
            6'h23: w_lw = 1'b1;
            6'h2B: w_sw = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_ir       = r_ir;
        w_tgt      = r_tgt;
        w_pend     = r_pend;
        w_read     = r_read;
        w_write    = r_write;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_wb_en    = 1'b0;
        w_wb_dst   = w_dst;
        w_wb_data  = w_alu;
        w_launch   = 1'b0;
        w_fetch_pc = r_pc;
        case (r_state)
            S_FETCH: begin
                if (!r_read) begin
                    w_launch = 1'b1;
                end else if (!waitrequest) begin
                    w_read  = 1'b0;
                    w_state = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                w_ir    = readdata;
                w_state = S_EXEC;
            end
            S_EXEC: begin
                // a pending target belongs to the branch before this slot
                w_pc       = r_pend ? r_tgt : w_pc4;
                w_pend     = w_br;
                w_tgt      = w_br_tgt;
                w_fetch_pc = w_pc;
                if (w_lw || w_sw) begin
                    w_state = S_MEM;
                    w_read  = w_lw;
                    w_write = w_sw;
                    w_addr  = w_mem_sum & 32'hFFFF_FFFC;
                    w_wdata = w_rtv;
                end else begin
                    w_wb_en  = w_alu_we;
                    w_launch = 1'b1;
                end
            end
            S_MEM: begin
                if (!waitrequest) begin
                    w_read  = 1'b0;
                    w_write = 1'b0;
                    if (r_read) w_state = S_MEM_WAIT;
                    else        w_launch = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                w_wb_en   = 1'b1;
                w_wb_dst  = w_rt;
                w_wb_data = readdata;
                w_launch  = 1'b1;
            end
            default: ;
        endcase
        if (w_launch) begin
            w_write = 1'b0;
            if (w_fetch_pc == 32'd0) begin
                w_state = S_HALT;
                w_read  = 1'b0;
            end else begin
                w_state = S_FETCH;
                w_read  = 1'b1;
                w_addr  = w_fetch_pc & 32'hFFFF_FFFC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_VECTOR;
            r_ir    <= '0;
            r_tgt   <= '0;
            r_pend  <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_ir    <= w_ir;
            r_tgt   <= w_tgt;
            r_pend  <= w_pend;
            r_read  <= w_read;
            r_write <= w_write;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
        end else if (w_wb_en && (w_wb_dst != 5'd0)) begin
            r_gpr[w_wb_dst] <= w_wb_data;
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: an ISA-level interpreter predicts every store
// and the final $v0; a monitor matches bus writes and checks hold rules.
module tb_mips_cpu_bus;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        active;
    logic [31:0] register_v0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'h0;
    logic [31:0] address;
    logic        write, read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;

    int checks = 0;
    int errors = 0;

    mips_cpu_bus #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(rst_n), .active(active),
        .register_v0(register_v0), .waitrequest(waitrequest),
        .readdata(readdata), .address(address), .write(write),
        .read(read), .writedata(writedata), .byteenable(byteenable)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } st_t;
    st_t         exp_q [$];
    logic [31:0] prog [$];
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] mmem [logic [31:0]];
    logic [31:0] mreg [32];
    logic [31:0] exp_v0;
    int          off;
    bit          stall_en = 0, busy = 0, f_forced = 0, s_forced = 0;
    int          stall_cnt = 0;
    logic        s_rd, s_wr, s_w;
    logic [31:0] s_a, s_d;
    logic        m_req = 0, m_wait = 0, m_rd = 0, m_wr = 0;
    logic [31:0] m_a = 0, m_d = 0;
    st_t         m_e;
    int rfn [13] = '{'h21, 'h23, 'h24, 'h25, 'h26, 'h00, 'h02,
                     'h03, 'h04, 'h06, 'h07, 'h2A, 'h2B};
    int iop [7]  = '{'h09, 'h0C, 'h0D, 'h0E, 'h0F, 'h0A, 'h0B};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rt_(input int rs, input int rt,
                                        input int rd, input int sh,
                                        input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] it_(input int op, input int rs,
                                        input int rt, input int imm);
        logic [31:0] v;
        v = 32'(imm);
        return {6'(op), 5'(rs), 5'(rt), v[15:0]};
    endfunction

    function automatic void em(input logic [31:0] w);
        prog.push_back(w);
    endfunction

    function automatic void st(input int r);
        em(it_('h2B, 28, r, off));
        off += 4;
    endfunction

    task automatic build_prog();
        logic [31:0] ja;
        prog.delete();
        off = 0;
        em(it_('h0F, 0, 28, 'hBFC0));
        em(it_('h0D, 28, 28, 'h0800));
        em(it_('h0F, 0, 8, 'h1111));
        em(it_('h0D, 8, 8, 'h2222));  st(8);
        em(rt_(8, 8, 9, 0, 'h21));    st(9);
        em(it_('h0F, 0, 10, 'h1111));
        em(rt_(9, 10, 11, 0, 'h23));  st(11);
        em(it_('h0D, 11, 12, 1));     st(12);
        em(it_('h0C, 11, 13, 'hFFFF)); st(13);
        em(it_('h0E, 13, 14, 'hFFFF)); st(14);
        em(it_('h09, 0, 15, 1));
        em(rt_(0, 15, 16, 31, 'h00)); st(16);
        em(rt_(0, 16, 17, 2, 'h03));  st(17);
        em(it_('h09, 0, 18, 3));
        em(rt_(18, 16, 19, 0, 'h07)); st(19);
        em(rt_(0, 19, 20, 4, 'h02));  st(20);
        em(it_('h0F, 0, 21, 'h1D00));
        em(rt_(15, 21, 22, 0, 'h06)); st(22);
        em(it_('h09, 0, 23, 'hFFFF));
        em(rt_(23, 15, 24, 0, 'h2A)); st(24);
        em(rt_(23, 15, 24, 0, 'h2B)); st(24);
        em(it_('h09, 0, 25, 5));
        em(it_('h0A, 25, 24, 6));     st(24);
        em(it_('h0B, 0, 24, 1));      st(24);
        em(it_('h0B, 25, 24, 'hFFFF)); st(24);
        em(it_('h23, 28, 26, 0));
        em(it_('h09, 26, 26, 1));     st(26);
        em(it_('h09, 0, 0, 5));       st(0);
        em(it_('h04, 0, 0, 2));
        em(it_('h09, 0, 3, 7));
        em(it_('h09, 3, 3, 100));     st(3);
        em(it_('h05, 3, 3, 2));
        em(it_('h09, 3, 3, 1));
        em(it_('h09, 3, 3, 1));       st(3);
        ja = RV + 32'((prog.size() + 3) * 4);
        em({6'h02, ja[27:2]});
        em(it_('h09, 3, 3, 16));
        em(it_('h09, 0, 3, 0));       st(3);
        em(it_('h20, 28, 3, 0));      st(3);
        for (int k = 3; k < 8; k++) begin
            em(it_('h0F, 0, k, int'($urandom_range(0, 65535))));
            em(it_('h0D, k, k, int'($urandom_range(0, 65535))));
        end
        for (int n = 0; n < 16; n++) begin
            int d = int'($urandom_range(3, 7));
            int s = int'($urandom_range(3, 7));
            int t = int'($urandom_range(3, 7));
            if ($urandom_range(0, 1) == 1)
                em(rt_(s, t, d, int'($urandom_range(0, 31)),
                       rfn[$urandom_range(0, 12)]));
            else
                em(it_(iop[$urandom_range(0, 6)], s, d,
                       int'($urandom_range(0, 65535))));
            st(d);
        end
        em(it_('h09, 0, 2, 'h1234));
        em(rt_(0, 0, 0, 0, 'h08));
        em(it_('h09, 2, 2, 1));
        em(it_('h09, 0, 2, 'hDEAD));
    endtask

    function automatic void wr(input int d, input logic [31:0] v);
        if (d != 0) mreg[d] = v;
    endfunction

    // plain ISA interpreter with a (pc, npc) pair for the delay slot
    task automatic model_run();
        logic [31:0] pc, npc, nnpc, ins, a, b, se, ze, ea;
        int op, fn, rs, rt, rd, sh;
        st_t e;
        mmem.delete();
        exp_q.delete();
        foreach (prog[i]) mmem[RV + 32'(i * 4)] = prog[i];
        foreach (mreg[i]) mreg[i] = 32'h0;
        pc = RV;
        npc = RV + 32'd4;
        for (int step = 0; step < 5000 && pc != 32'h0; step++) begin
            ins = mmem.exists(pc) ? mmem[pc] : 32'h0;
            op = int'(ins[31:26]); rs = int'(ins[25:21]);
            rt = int'(ins[20:16]); rd = int'(ins[15:11]);
            sh = int'(ins[10:6]);  fn = int'(ins[5:0]);
            a = mreg[rs]; b = mreg[rt];
            se = {{16{ins[15]}}, ins[15:0]};
            ze = {16'h0, ins[15:0]};
            nnpc = npc + 32'd4;
            case (op)
                0: case (fn)
                    'h00: wr(rd, b << sh);
                    'h02: wr(rd, b >> sh);
                    'h03: wr(rd, 32'($signed(b) >>> sh));
                    'h04: wr(rd, b << a[4:0]);
                    'h06: wr(rd, b >> a[4:0]);
                    'h07: wr(rd, 32'($signed(b) >>> a[4:0]));
                    'h08: nnpc = a;
                    'h21: wr(rd, a + b);
                    'h23: wr(rd, a - b);
                    'h24: wr(rd, a & b);
                    'h25: wr(rd, a | b);
                    'h26: wr(rd, a ^ b);
                    'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    'h2B: wr(rd, (a < b) ? 32'd1 : 32'd0);
                    default: ;
                endcase
                'h02: nnpc = {npc[31:28], ins[25:0], 2'b00};
                'h04: if (a == b) nnpc = npc + (se << 2);
                'h05: if (a != b) nnpc = npc + (se << 2);
                'h09: wr(rt, a + se);
                'h0A: wr(rt, ($signed(a) < $signed(se)) ? 32'd1 : 32'd0);
                'h0B: wr(rt, (a < se) ? 32'd1 : 32'd0);
                'h0C: wr(rt, a & ze);
                'h0D: wr(rt, a | ze);
                'h0E: wr(rt, a ^ ze);
                'h0F: wr(rt, {ins[15:0], 16'h0});
                'h23: begin
                    ea = (a + se) & 32'hFFFF_FFFC;
                    wr(rt, mmem.exists(ea) ? mmem[ea] : 32'h0);
                end
                'h2B: begin
                    ea = (a + se) & 32'hFFFF_FFFC;
                    mmem[ea] = b;
                    e.a = ea; e.d = b;
                    exp_q.push_back(e);
                end
                default: ;
            endcase
            pc = npc;
            npc = nnpc;
        end
        exp_v0 = mreg[2];
    endtask

    task automatic load_bus();
        bmem.delete();
        foreach (prog[i]) bmem[RV + 32'(i * 4)] = prog[i];
    endtask

    // bus slave: data and wait states change just after the rising edge
    initial begin
        forever begin
            @(negedge clk);
            s_rd = read; s_wr = write; s_a = address;
            s_d = writedata; s_w = waitrequest;
            @(posedge clk);
            #1;
            readdata = 32'hDEADBEEF;
            if (!rst_n) begin
                busy = 0; stall_cnt = 0; waitrequest = 1'b0;
            end else begin
                if ((s_rd || s_wr) && !s_w) begin
                    busy = 0;
                    if (s_rd) readdata = bmem.exists(s_a) ? bmem[s_a] : 32'h0;
                    else      bmem[s_a] = s_d;
                end
                if (stall_en && (read || write) && !busy) begin
                    busy = 1;
                    if (read && !f_forced) begin
                        stall_cnt = 3; f_forced = 1;
                    end else if (write && !s_forced) begin
                        stall_cnt = 3; s_forced = 1;
                    end else begin
                        stall_cnt = int'($urandom_range(0, 3));
                    end
                end
                waitrequest = stall_en && (stall_cnt > 0);
                if (stall_cnt > 0) stall_cnt--;
            end
        end
    end

    // monitor: pops the scoreboard on each accepted write
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_req = 0;
            end else begin
                if (m_req && m_wait) begin
                    checks++;
                    if ({read, write, address, writedata} !==
                        {m_rd, m_wr, m_a, m_d}) begin
                        errors++;
                        $display("FAIL hold: got %b%b %h %h expected %b%b %h %h",
                                 read, write, address, writedata,
                                 m_rd, m_wr, m_a, m_d);
                    end
                end
                if (read || write)
                    chk("byteenable", 32'(byteenable), 32'hF);
                if (write && !waitrequest) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL store: got write %h=%h expected none",
                                 address, writedata);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("store addr", address, m_e.a);
                        chk("store data", writedata, m_e.d);
                    end
                end
                m_req = read || write; m_wait = waitrequest;
                m_rd = read; m_wr = write; m_a = address; m_d = writedata;
            end
        end
    end

    task automatic run_prog(input bit stalls);
        int n;
        bit quiet;
        rst_n = 1'b0;
        stall_en = stalls; f_forced = 0; s_forced = 0;
        load_bus();
        model_run();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst read", 32'(read), 32'd0);
        chk("rst write", 32'(write), 32'd0);
        chk("rst addr", address, 32'd0);
        chk("rst active", 32'(active), 32'd1);
        chk("rst v0", register_v0, 32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!read && n < 20);
        chk("first read", 32'(read), 32'd1);
        chk("first addr", address, RV);
        chk("first active", 32'(active), 32'd1);
        n = 0;
        while (active === 1'b1 && n < 20000) begin @(negedge clk); n++; end
        chk("halt active", 32'(active), 32'd0);
        chk("halt v0", register_v0, exp_v0);
        chk("stores left", 32'(exp_q.size()), 32'd0);
        quiet = 1;
        repeat (10) begin
            @(negedge clk);
            if (read || write || active) quiet = 0;
        end
        chk("halt quiet", 32'(quiet), 32'd1);
    endtask

    task automatic abort_run();
        int n;
        rst_n = 1'b0;
        stall_en = 1; f_forced = 1; s_forced = 1;
        load_bus();
        model_run();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!((read || write) && waitrequest) && n < 200);
        chk("abort stall seen", 32'((read || write) && waitrequest), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort read", 32'(read), 32'd0);
        chk("abort write", 32'(write), 32'd0);
        chk("abort addr", address, 32'd0);
        chk("abort active", 32'(active), 32'd1);
        chk("abort v0", register_v0, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        build_prog();
        run_prog(0);
        run_prog(1);
        abort_run();
        run_prog(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
